// File: rtl/approx_mul_err_monitor_if.sv
// Operand/product bus between the error monitor and the multiplier under test.
// master drives operands and receives the product; slave is the multiplier side.
interface approx_mul_err_monitor_if #(
  parameter int unsigned W = 2
);
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic [2*W-1:0] mul_out;

  modport master (output mul_a, output mul_b, input mul_out);
  modport slave  (input mul_a, input mul_b, output mul_out);
endinterface

// File: rtl/approx_mul_err_monitor.sv
// Sweeps every {a,b} operand pair through an attached W x W multiplier and
// accumulates error statistics against the exact product.
module approx_mul_err_monitor #(
  parameter int unsigned W      = 2,
  parameter int unsigned SETTLE = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  approx_mul_err_monitor_if.master         mul,
  output logic [2*W:0]                     err_count,
  output logic [2*W-1:0]                   max_err,
  output logic [4*W-1:0]                   sum_err,
  output logic                             first_err_v,
  output logic [W-1:0]                     first_err_a,
  output logic [W-1:0]                     first_err_b
);

  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] LastCnt = CW'((SETTLE == 0) ? 0 : SETTLE - 1);

  typedef enum logic [1:0] {StIdle, StDrive, StSample, StDone} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [2*W:0]   cnt_err_q, cnt_err_d;
  logic [2*W-1:0] max_q, max_d;
  logic [4*W-1:0] sum_q, sum_d;
  logic           fv_q, fv_d;
  logic [W-1:0]   fa_q, fa_d, fb_q, fb_d;

  logic [2*W-1:0] exact, err;
  logic           sample, last;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_err_d = cnt_err_q;
    max_d     = max_q;
    sum_d     = sum_q;
    fv_d      = fv_q;
    fa_d      = fa_q;
    fb_d      = fb_q;
    sample    = 1'b0;
    last      = (a_q == '1) && (b_q == '1);
    exact     = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
    // Unsigned magnitude in both directions, so no wrap for out > exact.
    err       = (exact >= mul.mul_out) ? (exact - mul.mul_out) : (mul.mul_out - exact);

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d   = StDrive;
          cnt_d     = '0;
          a_d       = '0;
          b_d       = '0;
          cnt_err_d = '0;
          max_d     = '0;
          sum_d     = '0;
          fv_d      = 1'b0;
          fa_d      = '0;
          fb_d      = '0;
        end
      end
      StDrive: begin
        // With no settle time, DRIVE doubles as the sampling cycle.
        if (SETTLE == 0) begin
          sample = 1'b1;
        end else if (cnt_q == LastCnt) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StSample: sample = 1'b1;
      default:  state_d = StIdle;
    endcase

    if (sample) begin
      cnt_d = '0;
      sum_d = sum_q + (4*W)'(err);
      if (err > max_q) max_d = err;
      if (err != '0) begin
        cnt_err_d = cnt_err_q + (2*W+1)'(1);
        if (!fv_q) begin
          fv_d = 1'b1;
          fa_d = a_q;
          fb_d = b_q;
        end
      end
      if (last) begin
        state_d = StDone;
      end else begin
        state_d    = StDrive;
        {a_d, b_d} = {a_q, b_q} + (2*W)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_err_q <= '0;
      max_q     <= '0;
      sum_q     <= '0;
      fv_q      <= 1'b0;
      fa_q      <= '0;
      fb_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_err_q <= cnt_err_d;
      max_q     <= max_d;
      sum_q     <= sum_d;
      fv_q      <= fv_d;
      fa_q      <= fa_d;
      fb_q      <= fb_d;
    end
  end

  assign busy        = (state_q == StDrive) || (state_q == StSample);
  assign done        = (state_q == StDone);
  assign mul.mul_a   = a_q;
  assign mul.mul_b   = b_q;
  assign err_count   = cnt_err_q;
  assign max_err     = max_q;
  assign sum_err     = sum_q;
  assign first_err_v = fv_q;
  assign first_err_a = fa_q;
  assign first_err_b = fb_q;

endmodule

// File: tb/tb_approx_mul_err_monitor.sv
// Randomised bench: multiplier modelled as a product lookup table, results
// checked against statistics computed directly from that table.
module tb_approx_mul_err_monitor;

  localparam int unsigned W      = 2;
  localparam int unsigned SETTLE = 1;
  localparam int          NPairs = 16;
  localparam int          Sweep  = NPairs * (SETTLE + 1);
  localparam int          Bound  = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done;
  logic [4:0]  err_count;
  logic [3:0]  max_err;
  logic [7:0]  sum_err;
  logic        first_err_v;
  logic [1:0]  first_err_a, first_err_b;

  logic [3:0]  tbl [NPairs];
  int          n_checks = 0;
  int          n_pass = 0;
  int          order_q[$];

  int exp_cnt, exp_max, exp_sum, exp_v, exp_a, exp_b;

  approx_mul_err_monitor_if #(.W(W)) mif ();

  assign mif.mul_out = tbl[{mif.mul_a, mif.mul_b}];

  approx_mul_err_monitor #(.W(W), .SETTLE(SETTLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .mul         (mif.master),
    .err_count   (err_count),
    .max_err     (max_err),
    .sum_err     (sum_err),
    .first_err_v (first_err_v),
    .first_err_a (first_err_a),
    .first_err_b (first_err_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // mode 0 exact, 1 Kulkarni (3*3 -> 7), 2 all zero, 3 random corruption
  task automatic load_model(input int mode);
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        int p;
        p = a * b;
        case (mode)
          1:       if (a == 3 && b == 3) p = 7;
          2:       p = 0;
          3:       if ($urandom_range(0, 2) == 0) p = $urandom_range(0, 15);
          default: ;
        endcase
        tbl[a*4+b] = 4'(p);
      end
    end
  endtask

  task automatic compute_expected();
    exp_cnt = 0; exp_max = 0; exp_sum = 0; exp_v = 0; exp_a = 0; exp_b = 0;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        int e;
        e = a * b - int'(tbl[a*4+b]);
        if (e < 0) e = -e;
        exp_sum += e;
        if (e > exp_max) exp_max = e;
        if (e != 0) begin
          exp_cnt++;
          if (exp_v == 0) begin exp_v = 1; exp_a = a; exp_b = b; end
        end
      end
    end
  endtask

  task automatic check_stats(input string tag, input int c, input int mx, input int s,
                             input int v, input int fa, input int fb);
    check({tag, ".err_count"}, 32'(err_count), c);
    check({tag, ".max_err"}, 32'(max_err), mx);
    check({tag, ".sum_err"}, 32'(sum_err), s);
    check({tag, ".first_v"}, 32'(first_err_v), v);
    check({tag, ".first_a"}, 32'(first_err_a), fa);
    check({tag, ".first_b"}, 32'(first_err_b), fb);
  endtask

  // Pulses start and runs until done; optional extra start pulse or reset at cycle n.
  task automatic run_sweep(input string tag, input int pulse_at, input int rst_at,
                           output bit aborted);
    int n;
    aborted = 1'b0;
    order_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    check({tag, ".busy0"}, 32'(busy), 1);
    check({tag, ".done0"}, 32'(done), 0);
    while (!done && n < Bound) begin
      if (n % 2 == 1) order_q.push_back(int'({mif.mul_a, mif.mul_b}));
      if (n == pulse_at) start = 1'b1;
      if (n == rst_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        aborted = 1'b1;
        return;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
    end
    check({tag, ".cycles"}, 32'(n), Sweep);
    check({tag, ".busy_end"}, 32'(busy), 0);
    check({tag, ".last_a"}, 32'(mif.mul_a), 3);
    check({tag, ".last_b"}, 32'(mif.mul_b), 3);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"}, 32'(busy), 0);
    check({tag, ".done"}, 32'(done), 0);
    check({tag, ".mul_a"}, 32'(mif.mul_a), 0);
    check({tag, ".mul_b"}, 32'(mif.mul_b), 0);
    check_stats(tag, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit ab;
    load_model(0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all_zero("reset");

    load_model(0);
    run_sweep("t1", -1, -1, ab);
    check_stats("t1", 0, 0, 0, 0, 0, 0);

    load_model(1);
    run_sweep("t2", -1, -1, ab);
    check_stats("t2", 1, 2, 2, 1, 3, 3);

    load_model(2);
    run_sweep("t3", -1, -1, ab);
    check_stats("t3", 9, 9, 36, 1, 1, 1);

    load_model(0);
    run_sweep("t4", -1, -1, ab);
    check("t4.len", 32'(order_q.size()), NPairs);
    for (int i = 0; i < order_q.size() && i < NPairs; i++)
      check($sformatf("t4.pair%0d", i), 32'(order_q[i]), 32'(i));

    load_model(1);
    run_sweep("t5", 5, -1, ab);
    check_stats("t5", 1, 2, 2, 1, 3, 3);

    // pair (2,1) is index 9, i.e. cycles 18/19 of the sweep
    load_model(1);
    run_sweep("t6", -1, 18, ab);
    check("t6.aborted", 32'(ab), 1);
    check_all_zero("t6.rst");
    run_sweep("t6b", -1, -1, ab);
    check_stats("t6b", 1, 2, 2, 1, 3, 3);

    for (int r = 0; r < 4; r++) begin
      load_model(3);
      compute_expected();
      run_sweep($sformatf("rnd%0d", r), -1, -1, ab);
      check_stats($sformatf("rnd%0d", r), exp_cnt, exp_max, exp_sum, exp_v, exp_a, exp_b);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
